// File: rtl/boxcar_decimator.sv
// boxcar_decimator
//   Integrate-and-dump decimator for the free-running signed output of
//   boxcar_filter. Every block of N consecutive samples is summed at full
//   precision and the sum is presented on an AXI4-Stream master port that
//   has a single-entry output register. N is selected at runtime and is
//   latched at each frame start. A sum overwritten before it was accepted
//   raises a sticky overrun flag.
//
// Parameters
//   DATA_WIDTH    width of the signed input samples
//   LOG2_MAX_DEC  log2 of the largest decimation factor
//   OUT_WIDTH     derived width of the signed output sum
//
// Ports
//   clk            rising-edge clock
//   resetn         synchronous, active-low reset
//   din            signed sample, valid every clock
//   dec_factor     decimation factor N (0 acts as 1, clamps to 2^LOG2_MAX_DEC)
//   clear_overrun  clears overrun at a clock edge (an overwrite on the same edge wins)
//   m_axis_tdata   signed block sum
//   m_axis_tvalid  output register holds an unconsumed sum
//   m_axis_tready  downstream accept
//   overrun        sticky: a sum was overwritten before it was accepted
module boxcar_decimator #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int LOG2_MAX_DEC = 10,
    localparam int OUT_WIDTH    = DATA_WIDTH + LOG2_MAX_DEC
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [LOG2_MAX_DEC:0] dec_factor,
    input  logic                  clear_overrun,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overrun
);

    localparam int CW = LOG2_MAX_DEC + 1;

    localparam logic [CW-1:0]           MAX_DEC = {1'b1, {LOG2_MAX_DEC{1'b0}}};
    localparam logic [CW-1:0]           N_ONE   = 1;
    localparam logic [LOG2_MAX_DEC-1:0] CNT_ONE = 1;

    logic [OUT_WIDTH-1:0]    acc_q,    acc_d;
    logic [LOG2_MAX_DEC-1:0] count_q,  count_d;
    logic [CW-1:0]           n_lat_q,  n_lat_d;
    logic [OUT_WIDTH-1:0]    tdata_q,  tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    ovr_q,    ovr_d;

    logic [CW-1:0]        n_eff;
    logic [CW-1:0]        n_cur;
    logic                 frame_start;
    logic                 frame_end;
    logic                 overwrite;
    logic [OUT_WIDTH-1:0] din_ext;
    logic [OUT_WIDTH-1:0] sum;

    always_comb begin
        if (dec_factor == '0) begin
            n_eff = N_ONE;
        end else if (dec_factor > MAX_DEC) begin
            n_eff = MAX_DEC;
        end else begin
            n_eff = dec_factor;
        end

        // At a frame start the freshly computed factor governs this very edge,
        // so a one-sample frame can both start and end here.
        frame_start = (count_q == '0);
        n_cur       = frame_start ? n_eff : n_lat_q;
        frame_end   = ({1'b0, count_q} == (n_cur - N_ONE));

        din_ext = {{LOG2_MAX_DEC{din[DATA_WIDTH-1]}}, din};
        sum     = acc_q + din_ext;

        overwrite = frame_end && tvalid_q && !m_axis_tready;

        acc_d    = acc_q;
        count_d  = count_q;
        n_lat_d  = frame_start ? n_eff : n_lat_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        ovr_d    = ovr_q;

        if (frame_end) begin
            acc_d    = '0;
            count_d  = '0;
            tdata_d  = sum;
            tvalid_d = 1'b1;
        end else begin
            acc_d   = sum;
            count_d = count_q + CNT_ONE;
            if (tvalid_q && m_axis_tready) begin
                tvalid_d = 1'b0;
            end
        end

        if (overwrite) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc_q    <= '0;
            count_q  <= '0;
            n_lat_q  <= N_ONE;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            count_q  <= count_d;
            n_lat_q  <= n_lat_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
// tb_boxcar_decimator
//   Scoreboard bench for boxcar_decimator. A frame-level reference model
//   collects samples into a queue, sums each completed frame and pushes the
//   sum to the scoreboard; a monitor pops and compares on every handshake.
module tb_boxcar_decimator;

    localparam int DW  = 8;
    localparam int LD  = 10;
    localparam int OW  = DW + LD;
    localparam int MAXN = 1 << LD;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [DW-1:0]        din;
    logic [LD:0]          dec_factor;
    logic                 clear_overrun;
    logic signed [OW-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 overrun;

    boxcar_decimator #(.DATA_WIDTH(DW), .LOG2_MAX_DEC(LD)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .din           (din),
        .dec_factor    (dec_factor),
        .clear_overrun (clear_overrun),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model state
    int frame_q[$];
    int frame_n   = 1;
    int exp_q[$];
    bit exp_valid = 1'b0;
    bit exp_ovr   = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input int d, input int dec, input bit rdy,
                                       input bit clr, input bit rstn);
        int s;
        bit set_ovr;
        if (!rstn) begin
            if (exp_valid && !rdy) void'(exp_q.pop_back());
            frame_q.delete();
            frame_n   = 1;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            return;
        end
        if (frame_q.size() == 0)
            frame_n = (dec == 0) ? 1 : ((dec > MAXN) ? MAXN : dec);
        frame_q.push_back(d);
        set_ovr = 1'b0;
        if (frame_q.size() == frame_n) begin
            s = 0;
            foreach (frame_q[i]) s += frame_q[i];
            frame_q.delete();
            if (exp_valid && !rdy) begin
                void'(exp_q.pop_back());
                set_ovr = 1'b1;
            end
            exp_q.push_back(s);
            exp_valid = 1'b1;
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        if (set_ovr) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
    endfunction

    // Inputs change 1 time unit after a rising edge; the model sees exactly
    // the values the DUT sampled at that edge.
    task automatic cycle(input int d, input int dec, input bit rdy,
                         input bit clr, input bit rstn);
        din           = DW'(d);
        dec_factor    = (LD + 1)'(dec);
        m_axis_tready = rdy;
        clear_overrun = clr;
        resetn        = rstn;
        @(posedge clk);
        model_step(d, dec, rdy, clr, rstn);
        #1;
    endtask

    task automatic align();
        while (frame_q.size() != 0) cycle(0, 1, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: compares handshake data against the scoreboard and control
    // outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tvalid", int'(m_axis_tvalid), int'(exp_valid));
            chk("overrun", int'(overrun), int'(exp_ovr));
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got tdata %0d, expected no output (t=%0t)",
                             m_axis_tdata, $time);
                end else begin
                    chk("tdata", int'(m_axis_tdata), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int dl1[8] = '{1, -1, 10, -2, -5, -6, 0, -1};
        int dl2[3] = '{3, -4, 7};
        int decs[8] = '{0, 1, 2, 3, 4, 7, 1024, 1500};
        int dsel;

        // Reset
        cycle(0, 4, 1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        cycle(0, 4, 1'b1, 1'b0, 1'b0);
        chk("rst_tdata", int'(m_axis_tdata), 0);
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_overrun", int'(overrun), 0);

        // N=4 basic frames
        for (int i = 0; i < 8; i++) begin
            cycle(dl1[i], 4, 1'b1, 1'b0, 1'b1);
            if (i == 3) chk("n4_sum0", int'(m_axis_tdata), 8);
            if (i == 7) chk("n4_sum1", int'(m_axis_tdata), -12);
        end

        // N=0 and N=1 pass-through
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) begin
                cycle(dl2[i], k, 1'b1, 1'b0, 1'b1);
                chk("n1_pass", int'(m_axis_tdata), dl2[i]);
            end

        // Full scale
        align();
        for (int i = 0; i < MAXN; i++) cycle(-128, 1024, 1'b1, 1'b0, 1'b1);
        chk("full_neg", int'(m_axis_tdata), -131072);
        for (int i = 0; i < MAXN; i++) cycle(127, 1024, 1'b1, 1'b0, 1'b1);
        chk("full_pos", int'(m_axis_tdata), 130048);
        cycle(0, 4, 1'b1, 1'b0, 1'b1);
        align();

        // Backpressure and overrun
        for (int i = 0; i < 8; i++) cycle(dl1[i], 4, 1'b0, 1'b0, 1'b1);
        chk("bp_tdata", int'(m_axis_tdata), -12);
        chk("bp_overrun", int'(overrun), 1);
        cycle(3, 4, 1'b0, 1'b1, 1'b1);
        chk("ovr_clear", int'(overrun), 0);
        cycle(3, 4, 1'b0, 1'b0, 1'b1);
        cycle(3, 4, 1'b0, 1'b0, 1'b1);
        cycle(3, 4, 1'b0, 1'b1, 1'b1);
        chk("ovr_set_wins", int'(overrun), 1);
        chk("ovr_tdata", int'(m_axis_tdata), 12);
        cycle(0, 4, 1'b1, 1'b0, 1'b1);
        align();

        // Mid-frame factor change
        cycle(1, 4, 1'b1, 1'b0, 1'b1);
        cycle(2, 4, 1'b1, 1'b0, 1'b1);
        cycle(3, 2, 1'b1, 1'b0, 1'b1);
        cycle(4, 2, 1'b1, 1'b0, 1'b1);
        chk("mid_n4", int'(m_axis_tdata), 10);
        cycle(10, 2, 1'b1, 1'b0, 1'b1);
        cycle(-2, 2, 1'b1, 1'b0, 1'b1);
        chk("mid_n2", int'(m_axis_tdata), 8);
        align();

        // Reset mid-frame
        cycle(5, 4, 1'b0, 1'b0, 1'b1);
        cycle(5, 4, 1'b0, 1'b0, 1'b1);
        cycle(0, 4, 1'b0, 1'b0, 1'b0);
        chk("mrst_tdata", int'(m_axis_tdata), 0);
        chk("mrst_tvalid", int'(m_axis_tvalid), 0);
        chk("mrst_overrun", int'(overrun), 0);
        for (int i = 0; i < 4; i++) cycle(1, 4, 1'b1, 1'b0, 1'b1);
        chk("mrst_sum", int'(m_axis_tdata), 4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            dsel = $urandom_range(0, 7);
            if (decs[dsel] >= 1024 && $urandom_range(0, 9) != 0) dsel = $urandom_range(0, 5);
            cycle(int'($urandom_range(0, 255)) - 128, decs[dsel],
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 299) != 0));
        end

        // Drain and final reset; everything loaded must have been consumed or dropped
        for (int i = 0; i < 4; i++) cycle(0, 1, 1'b1, 1'b0, 1'b1);
        cycle(0, 1, 1'b1, 1'b0, 1'b0);
        chk("sb_empty", exp_q.size(), 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
